// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - splits 32-bit instruction words into big-endian byte writes
//
// Purpose: fills the byte-addressed instruction memory from a valid/ready word
// stream. Each accepted word becomes four consecutive byte writes, MSB first,
// starting at a word-aligned base address. The address pointer wraps modulo 2**ADDR_W.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start       one-cycle load request, honoured only while idle
//   base_addr   first byte address (bits [1:0] ignored)
//   word_count  number of words to load (0 completes immediately)
//   in_valid    source presents a word on in_word
//   in_word     instruction word
//   in_ready    loader takes a word this cycle
//   mem_we      byte write strobe
//   mem_addr    byte write address
//   mem_wdata   byte write data
//   busy        load in progress
//   checksum    modulo-256 byte sum of the current load (INSTR_LOADER_CHECKSUM_EN only)
//   done        one-cycle completion pulse
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN

module instr_mem_loader #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_word,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
`ifdef INSTR_LOADER_CHECKSUM_EN
   output logic [7:0]        checksum,
`endif
   output logic              done
);

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  remaining;
   logic [1:0]        beat;
   logic [31:0]       word;      // left-shifting copy of the word; [31:24] is the next byte
   logic              accept;
   logic              issue;     // a byte write is launched at this edge
   logic [7:0]        byte_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt      = state;
      issue    = 1'b0;
      byte_nxt = 8'h00;
      accept   = (state == ACCEPT) && in_valid && in_ready;
      case (state)
         IDLE: begin
            if (start) nxt = (word_count == '0) ? DONE : ACCEPT;
         end
         ACCEPT: begin
            // beat 0 is launched on the accepting edge itself, straight from in_word
            if (accept) begin
               nxt      = WRITE;
               issue    = 1'b1;
               byte_nxt = in_word[31:24];
            end
         end
         WRITE: begin
            if (beat == 2'd3) begin
               nxt = (remaining == CNT_W'(1)) ? DONE : ACCEPT;
            end else begin
               issue    = 1'b1;
               byte_nxt = word[31:24];
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         ptr       <= '0;
         remaining <= '0;
         beat      <= 2'd0;
         word      <= 32'h0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         checksum  <= 8'h00;
`endif
      end else begin
         in_ready <= (nxt == ACCEPT);
         mem_we   <= issue;
         // done follows the DONE state by one cycle; busy is held through that pulse
         done     <= (state == DONE);
         busy     <= (nxt != IDLE) || (state == DONE);

         if (issue) begin
            mem_addr  <= ptr;
            mem_wdata <= byte_nxt;
            ptr       <= ptr + ADDR_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum  <= checksum + byte_nxt;
`endif
         end

         if (state == IDLE && start) begin
            ptr       <= base_addr & ~ADDR_W'(3);
            remaining <= word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum  <= 8'h00;
`endif
         end

         if (accept) begin
            word <= {in_word[23:0], 8'h00};
            beat <= 2'd0;
         end

         if (state == WRITE) begin
            if (beat == 2'd3) begin
               remaining <= remaining - CNT_W'(1);
            end else begin
               beat <= beat + 2'd1;
               word <= {word[23:0], 8'h00};
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader

module tb_instr_mem_loader;

   localparam int ADDR_W = 8;
   localparam int CNT_W  = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              in_valid;
   logic [31:0]       in_word;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]        checksum;
`endif

   always #5 clk = ~clk;

   instr_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_word    (in_word),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
`ifdef INSTR_LOADER_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .done       (done)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // write log of the most recent load
   logic [7:0]  wa [64];
   logic [7:0]  wd [64];
   int          wc [64];
   int          nw, done_at, done_cnt, busy_at_done, rdy_cycles, overlap;
   logic [31:0] words [4];
   int          nwords;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a load in cycle 0 and watches cycles 1..max_cycles. in_valid stays low
   // until cycle vdelay; start is re-pulsed in cycle restart_at (if >= 0).
   task automatic run_load(input string tag, input logic [7:0] base, input int cnt,
                           input int vdelay, input int restart_at, input int max_cycles);
      logic hs;
      int   widx;
      nw = 0; done_at = -1; done_cnt = 0; busy_at_done = 0; rdy_cycles = 0; overlap = 0;
      widx       = 0;
      base_addr  = base;
      word_count = CNT_W'(cnt);
      start      = 1'b1;
      in_word    = words[0];
      in_valid   = (vdelay == 0) && (nwords > 0);
      for (int k = 1; k <= max_cycles; k++) begin
         hs = in_valid && in_ready;
         tick();
         if (hs) widx++;
         start = (k == restart_at);
         if (widx < nwords) in_word = words[widx];
         in_valid = (k >= vdelay) && (widx < nwords);
         if (mem_we) begin
            if (nw < 64) begin
               wa[nw] = mem_addr;
               wd[nw] = mem_wdata;
               wc[nw] = k;
            end
            nw++;
         end
         if (mem_we && in_ready) overlap++;
         if (in_ready && !mem_we && k <= vdelay) rdy_cycles++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at      = k;
               busy_at_done = busy;
            end
         end
         if (done_at >= 0 && k >= done_at + 3) break;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      check({tag, "_done_seen"}, 32'(done_at >= 0), 32'd1);
   endtask

   task automatic check_log(input string tag, input logic [7:0] a0,
                            input logic [7:0] d [8], input int n);
      logic [7:0] ea;
      check({tag, "_nwrites"}, nw, n);
      for (int i = 0; i < n && i < nw; i++) begin
         ea = a0 + 8'(i);
         check($sformatf("%s_addr%0d", tag, i), wa[i], ea);
         check($sformatf("%s_data%0d", tag, i), wd[i], d[i]);
      end
   endtask

   logic [7:0] exp_single [8] = '{8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] exp_bp     [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
   logic [7:0] exp_wrap   [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      in_valid = 1'b0; in_word = 32'h0; nwords = 0;
      for (int i = 0; i < 4; i++) words[i] = 32'h0;
      tick(); tick();
      check("rst_busy",     busy,      1'b0);
      check("rst_done",     done,      1'b0);
      check("rst_in_ready", in_ready,  1'b0);
      check("rst_mem_we",   mem_we,    1'b0);
      check("rst_mem_addr", mem_addr,  8'h00);
      check("rst_mem_data", mem_wdata, 8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
      check("rst_checksum", checksum,  8'h00);
`endif
      rst = 1'b1;
      tick();

      // reset asserted during beat 2 of a load
      words[0] = 32'hDEADBEEF; nwords = 1;
      base_addr = 8'h40; word_count = 7'd1; start = 1'b1;
      in_word = words[0]; in_valid = 1'b1;
      tick(); start = 1'b0;
      check("midrst_accept_ready", in_ready, 1'b1);
      tick(); in_valid = 1'b0;
      tick(); tick();
      check("midrst_beat2_we",   mem_we,    1'b1);
      check("midrst_beat2_addr", mem_addr,  8'h42);
      check("midrst_beat2_data", mem_wdata, 8'hBE);
      #2 rst = 1'b0;
      #1;
      check("midrst_we",       mem_we,   1'b0);
      check("midrst_busy",     busy,     1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_addr",     mem_addr, 8'h00);
      tick();
      rst = 1'b1;
      tick(); tick();
      check("midrst_idle_busy",  busy,     1'b0);
      check("midrst_idle_ready", in_ready, 1'b0);

      // single word after reset recovery
      words[0] = 32'h8C220004; nwords = 1;
      run_load("single", 8'h10, 1, 0, -1, 30);
      check_log("single", 8'h10, exp_single, 4);
      check("single_first_we_cycle", wc[0], 2);
      check("single_last_we_cycle",  wc[3], 5);
      check("single_done_cycle",     done_at, 7);
      check("single_done_count",     done_cnt, 1);
      check("single_busy_at_done",   busy_at_done, 1);
      check("single_ready_vs_we",    overlap, 0);
      check("single_idle_busy",      busy, 1'b0);

      // back-pressure: no valid for 10 cycles
      words[0] = 32'hA1B2C3D4; words[1] = 32'h0F1E2D3C; nwords = 2;
      run_load("bp", 8'h00, 2, 10, -1, 60);
      check("bp_ready_wait_cycles", rdy_cycles, 10);
      check_log("bp", 8'h00, exp_bp, 8);
      check("bp_first_we_cycle", wc[0], 11);
      check("bp_done_cycle",     done_at, 21);
      check("bp_done_count",     done_cnt, 1);
      check("bp_ready_vs_we",    overlap, 0);

      // alignment and address wrap
      words[0] = 32'h11223344; words[1] = 32'h55667788; nwords = 2;
      run_load("wrap", 8'hFE, 2, 0, -1, 40);
      check_log("wrap", 8'hFC, exp_wrap, 8);
      check("wrap_done_cycle", done_at, 12);
      check("wrap_done_count", done_cnt, 1);

      // zero word count
      nwords = 0;
      run_load("zero", 8'h30, 0, 0, -1, 10);
      check("zero_nwrites",      nw, 0);
      check("zero_done_cycle",   done_at, 2);
      check("zero_done_count",   done_cnt, 1);
      check("zero_busy_at_done", busy_at_done, 1);

      // start during WRITE is ignored
      words[0] = 32'hCAFEF00D; words[1] = 32'h12345678; words[2] = 32'h9ABCDEF0; nwords = 3;
      run_load("restart", 8'h80, 3, 0, 3, 40);
      check("restart_nwrites",   nw, 12);
      check("restart_last_addr", wa[11], 8'h8B);
      check("restart_last_data", wd[11], 8'hF0);
      check("restart_done_cycle", done_at, 17);
      check("restart_done_count", done_cnt, 1);
      check("restart_idle_busy",  busy, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
      words[0] = 32'h01020304; words[1] = 32'hFFFFFFFF; nwords = 2;
      run_load("cks", 8'h20, 2, 0, -1, 40);
      check("cks_nwrites", nw, 8);
      check("cks_value",   checksum, 8'h06);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
